// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// byte-enable patterns and request decode helpers.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B  = 4'b0001;
    localparam logic [3:0] BE_LO = 4'b0011;
    localparam logic [3:0] BE_HI = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Low two funct3 bits carry the width; the illegal codes fall to word.
    function automatic size_t size_of(input logic [2:0] f3);
        unique case (f3[1:0])
            2'b00:   size_of = SZ_B;
            2'b01:   size_of = SZ_H;
            default: size_of = SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] be_of(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        unique case (size_of(f3))
            SZ_B:    be_of = BE_B << a;
            SZ_H:    be_of = a[1] ? BE_HI : BE_LO;
            default: be_of = BE_W;
        endcase
    endfunction

    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        unique case (size_of(f3))
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = a[0];
            default: misaligned = |a;
        endcase
    endfunction

    function automatic logic [31:0] lanes(
        input logic [2:0]  f3,
        input logic [31:0] wd
    );
        unique case (size_of(f3))
            SZ_B:    lanes = {4{wd[7:0]}};
            SZ_H:    lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: picks the addressed byte/halfword lane out of the read
// word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;
    size_t       size;

    assign sext = ~funct3[2];
    assign size = size_of(funct3);

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
    end

    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        unique case (1'b1)
            size == SZ_B: data = {{24{sext & byte_sel[7]}}, byte_sel};
            size == SZ_H: data = {{16{sext & half_sel[15]}}, half_sel};
            default:      data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per request,
// with misalignment trap, bus timeout and aligned load result.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_timeout,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    state_t           state;
    state_t           state_nxt;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] cnt;
    logic             mis_q;
    logic             to_q;
    logic             req_bad;
    logic             cnt_end;
    logic [31:0]      aligned;

    assign req_bad = misaligned(req_funct3, req_addr[1:0]);
    assign cnt_end = (cnt == CNT_W'(TIMEOUT - 1));

    lsu_load_align u_align (
        .rdata  (dmem_rdata),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (aligned)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid)
                    state_nxt = req_bad ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (dmem_ack || cnt_end)
                    state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            cnt       <= '0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
            load_data <= 32'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid && !req_bad) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        be_q    <= be_of(req_funct3, req_addr[1:0]);
                        wdata_q <= lanes(req_funct3, req_wdata);
                        cnt     <= '0;
                    end else if (req_valid) begin
                        mis_q     <= 1'b1;
                        load_data <= 32'h0;
                    end
                end
                S_ACCESS: begin
                    // Ack takes priority over an expiring timeout.
                    if (dmem_ack) begin
                        load_data <= we_q ? 32'h0 : aligned;
                    end else if (cnt_end) begin
                        to_q      <= 1'b1;
                        load_data <= 32'h0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    mis_q <= 1'b0;
                    to_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign done        = (state == S_RESP);
    assign misalign    = mis_q;
    assign bus_timeout = to_q;
    assign stall       = rst_n & req_valid & ~done;

    assign dmem_req   = (state == S_ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued when
// a request is driven and compared when done pulses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misalign;
    logic        bus_timeout;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        to;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .done        (done),
        .load_data   (load_data),
        .misalign    (misalign),
        .bus_timeout (bus_timeout),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ackd: index of the dmem_req cycle in which ack is returned, -1 = never.
    task automatic run_op(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input int          ackd,
        input logic [3:0]  ebe,
        input logic [31:0] ewd,
        input logic [31:0] eld,
        input logic        emis,
        input logic        eto,
        input int          elat
    );
        exp_t e;
        int   r;
        bit   fin;
        e = '{ld: eld, mis: emis, to: eto, lat: elat};
        sb.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        r   = 0;
        fin = 1'b0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                e = sb.pop_front();
                check("latency", c, e.lat);
                check("load_data", load_data, e.ld);
                check("misalign", {31'b0, misalign}, {31'b0, e.mis});
                check("bus_timeout", {31'b0, bus_timeout}, {31'b0, e.to});
                check("stall_at_done", {31'b0, stall}, 32'd0);
                req_valid = 1'b0;
                dmem_ack  = 1'b0;
                fin       = 1'b1;
            end else begin
                check("stall_busy", {31'b0, stall}, 32'd1);
                if (dmem_req) begin
                    check("bus_on_misalign", {31'b0, emis}, 32'd0);
                    check("dmem_we", {31'b0, dmem_we}, {31'b0, we});
                    check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
                    check("dmem_be", {28'b0, dmem_be}, {28'b0, ebe});
                    check("dmem_wdata", dmem_wdata, ewd);
                    if (r == ackd) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = rd;
                    end else begin
                        dmem_ack   = 1'b0;
                        dmem_rdata = 32'h5A5A_5A5A;
                    end
                    r++;
                end else begin
                    dmem_ack = 1'b0;
                end
            end
        end
        if (!fin) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
            req_valid = 1'b0;
            dmem_ack  = 1'b0;
        end
        @(posedge clk);
        #1;
        check("req_after", {31'b0, dmem_req}, 32'd0);
        check("done_after", {31'b0, done}, 32'd0);
        check("stall_after", {31'b0, stall}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        dmem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_load", load_data, 32'h0);
        check("rst_be", {28'b0, dmem_be}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // we f3 addr wdata rdata ackd be wdata_exp ld mis to lat
        run_op(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0,
               4'b1111, 32'h0, 32'hDEADBEEF, 0, 0, 2);
        run_op(0, 3'b000, 32'h103, 0, 32'h80FF_0000, 0,
               4'b1000, 32'h0, 32'hFFFFFF80, 0, 0, 2);
        run_op(0, 3'b100, 32'h103, 0, 32'h80FF_0000, 2,
               4'b1000, 32'h0, 32'h00000080, 0, 0, 4);
        run_op(1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFF_FFFF, 1,
               4'b1100, 32'hABCDABCD, 32'h0, 0, 0, 3);
        run_op(0, 3'b001, 32'h102, 0, 32'h8001_0000, 0,
               4'b1100, 32'h0, 32'hFFFF8001, 0, 0, 2);
        run_op(0, 3'b101, 32'h100, 0, 32'h0000_F00F, 0,
               4'b0011, 32'h0, 32'h0000F00F, 0, 0, 2);
        run_op(1, 3'b000, 32'h301, 32'h0000_00A5, 0, 0,
               4'b0010, 32'hA5A5A5A5, 32'h0, 0, 0, 2);
        run_op(0, 3'b011, 32'h104, 0, 32'h1357_9BDF, 0,
               4'b1111, 32'h0, 32'h13579BDF, 0, 0, 2);
        run_op(0, 3'b010, 32'h101, 0, 0, 0,
               4'b0000, 32'h0, 32'h0, 1, 0, 1);
        run_op(0, 3'b001, 32'h105, 0, 0, 0,
               4'b0000, 32'h0, 32'h0, 1, 0, 1);
        run_op(0, 3'b010, 32'h108, 0, 0, -1,
               4'b1111, 32'h0, 32'h0, 0, 1, 17);
        run_op(0, 3'b010, 32'h10C, 0, 32'hCAFE_F00D, 15,
               4'b1111, 32'h0, 32'hCAFEF00D, 0, 0, 17);

        // Stray ack while idle must not start anything.
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        check("stray_ack_done", {31'b0, done}, 32'd0);
        check("stray_ack_req", {31'b0, dmem_req}, 32'd0);

        // Asynchronous reset in the middle of an access.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h400;
        @(posedge clk);
        #1;
        check("pre_rst_req", {31'b0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req", {31'b0, dmem_req}, 32'd0);
        check("async_stall", {31'b0, stall}, 32'd0);
        check("async_done", {31'b0, done}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(0, 3'b010, 32'h400, 0, 32'h0BAD_F00D, 1,
               4'b1111, 32'h0, 32'h0BADF00D, 0, 0, 3);

        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
